// File: rtl/sm_reg_dump_tx_if.sv
// Register-dump bus: start/busy/done handshake, CPU readout port and UART line.
// Latency: none, wires only.
// Backpressure: none; the dumper ignores start while busy.
interface sm_reg_dump_tx_if;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic        tx;

    // Host / CPU side: issues start, answers regAddr with regData, listens on tx
    modport master (
        output start,
        output regData,
        input  busy,
        input  done,
        input  regAddr,
        input  tx
    );

    // Dumper side
    modport slave (
        input  start,
        input  regData,
        output busy,
        output done,
        output regAddr,
        output tx
    );
endinterface

// File: rtl/sm_reg_dump_tx.sv
// Debug register dumper: walks regAddr 0..31, captures regData, sends 0xA5 + 128 bytes as UART 8N1.
// Latency: start bit the cycle after start is accepted; done 1+10*B+32*(SETTLE+1+40*B) cycles later.
// Backpressure: none; start is ignored while busy and the line runs at a fixed baud rate.
module sm_reg_dump_tx #(
    parameter int BAUD_DIV = 16,
    parameter int SETTLE   = 2
) (
    input  logic            clk,
    input  logic            rst,
    sm_reg_dump_tx_if.slave dump
);
    localparam int              BW          = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int              SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [BW-1:0]   BAUD_LAST   = BW'(BAUD_DIV - 1);
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [7:0]      SYNC_BYTE   = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_SETTLE,
        S_CAPT,
        S_SEND,
        S_FIN
    } state_t;

    state_t          state_q;
    logic [BW-1:0]   baud_q;
    logic [3:0]      bit_q;       // 0 = start bit, 1..8 = data, 9 = stop bit
    logic [1:0]      byte_idx_q;
    logic [SW-1:0]   settle_q;
    logic [31:0]     word_q;
    logic [4:0]      addr_q;
    logic            tx_q;
    logic            busy_q;
    logic            done_q;

    logic [7:0]      cur_byte;
    logic            next_bit_val;
    logic            bit_end;

    // Byte currently on the line: sync byte in SYNC, otherwise the selected byte of the frozen word
    always_comb begin
        cur_byte = SYNC_BYTE;
        if (state_q == S_SEND) begin
            case (byte_idx_q)
                2'd0:    cur_byte = word_q[7:0];
                2'd1:    cur_byte = word_q[15:8];
                2'd2:    cur_byte = word_q[23:16];
                default: cur_byte = word_q[31:24];
            endcase
        end
    end

    // Value of the frame bit that follows bit_q: data bit bit_q for 0..7, stop bit after data bit 7
    always_comb begin
        next_bit_val = 1'b1;
        if (bit_q < 4'd8) begin
            next_bit_val = cur_byte[bit_q[2:0]];
        end
    end

    assign bit_end = (baud_q == BAUD_LAST);

    // Dump sequencer and UART framer; tx/busy/done/regAddr are all registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_idx_q <= '0;
            settle_q   <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (dump.start) begin
                        state_q <= S_SYNC;
                        busy_q  <= 1'b1;
                        tx_q    <= 1'b0;
                        baud_q  <= '0;
                        bit_q   <= '0;
                    end
                end

                S_SYNC, S_SEND: begin
                    if (!bit_end) begin
                        baud_q <= baud_q + 1'b1;
                    end else begin
                        baud_q <= '0;
                        if (bit_q != 4'd9) begin
                            bit_q <= bit_q + 4'd1;
                            tx_q  <= next_bit_val;
                        end else begin
                            // Last cycle of a stop bit: pick what follows the frame
                            bit_q <= '0;
                            if (state_q == S_SYNC) begin
                                state_q  <= S_SETTLE;
                                settle_q <= '0;
                                addr_q   <= '0;
                                tx_q     <= 1'b1;
                            end else if (byte_idx_q != 2'd3) begin
                                // Next byte of the same word starts with no idle gap
                                byte_idx_q <= byte_idx_q + 2'd1;
                                tx_q       <= 1'b0;
                            end else if (addr_q == 5'd31) begin
                                state_q <= S_FIN;
                                addr_q  <= '0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                tx_q    <= 1'b1;
                            end else begin
                                state_q  <= S_SETTLE;
                                addr_q   <= addr_q + 5'd1;
                                settle_q <= '0;
                                tx_q     <= 1'b1;
                            end
                        end
                    end
                end

                S_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_q <= S_CAPT;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end

                S_CAPT: begin
                    // regData has been stable for SETTLE cycles; freeze it for the whole word
                    word_q     <= dump.regData;
                    byte_idx_q <= '0;
                    bit_q      <= '0;
                    baud_q     <= '0;
                    tx_q       <= 1'b0;
                    state_q    <= S_SEND;
                end

                S_FIN: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dump.tx      = tx_q;
    assign dump.busy    = busy_q;
    assign dump.done    = done_q;
    assign dump.regAddr = addr_q;
endmodule

// File: tb/tb_sm_reg_dump_tx.sv
// Bench for sm_reg_dump_tx: two instances (B=4/S=2 and B=2/S=1), UART decoders feed a byte scoreboard.
// Latency: checks done timing against hand-computed cycle counts.
// Backpressure: start pulses during busy and start tied high are exercised.
module tb_sm_reg_dump_tx;
    localparam int BA      = 4;
    localparam int SA      = 2;
    localparam int BB      = 2;
    localparam int SB      = 1;
    localparam int DONE_A  = 5257;   // 1 + 40 + 32*(3 + 160)
    localparam int DONE_B  = 2645;   // 1 + 20 + 32*(2 + 80)
    localparam int ABORT_C = 1277;   // first cycle of bit 3, byte 2, reg 7 (B=4, S=2)
    localparam int LIMIT   = 20000;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    sm_reg_dump_tx_if if_a ();
    sm_reg_dump_tx_if if_b ();

    sm_reg_dump_tx #(.BAUD_DIV(BA), .SETTLE(SA)) dut_a (.clk(clk), .rst(rst_a), .dump(if_a));
    sm_reg_dump_tx #(.BAUD_DIV(BB), .SETTLE(SB)) dut_b (.clk(clk), .rst(rst_b), .dump(if_b));

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int         done_cnt[2] = '{0, 0};
    int         rx_cnt[2] = '{-1, -1};
    logic [7:0] rx_sh[2];

    int          mode_a = 0;
    int          stab_a = 0;
    logic [4:0]  last_addr_a = 5'd0;
    logic [31:0] garb_a = 32'h0;

    always #5 clk = ~clk;

    // CPU readout model: 0x1000_00nn, or in capture-window mode reg 5 is only valid during CAPT
    assign if_a.regData = (mode_a == 1 && if_a.regAddr == 5'd5) ?
                          ((stab_a == SA) ? 32'hDEAD_BEEF : garb_a) :
                          (32'h1000_0000 | {27'd0, if_a.regAddr});
    assign if_b.regData = 32'h1000_0000 | {27'd0, if_b.regAddr};

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic got_byte(int i, logic [7:0] b);
        logic [7:0] e;
        if (i == 0) begin
            if (exp_q0.size() == 0) begin
                checks++; failures++;
                $display("FAIL uart_a_unexpected actual=%02h expected=none at %0t", b, $time);
                return;
            end
            e = exp_q0.pop_front();
            check("uart_a_byte", {24'd0, b}, {24'd0, e});
        end else begin
            if (exp_q1.size() == 0) begin
                checks++; failures++;
                $display("FAIL uart_b_unexpected actual=%02h expected=none at %0t", b, $time);
                return;
            end
            e = exp_q1.pop_front();
            check("uart_b_byte", {24'd0, b}, {24'd0, e});
        end
    endtask

    task automatic push_stream(int i, bit special5, int nbytes);
        logic [7:0]  s[$];
        logic [31:0] w;
        s.push_back(8'hA5);
        for (int r = 0; r < 32; r++) begin
            w = (special5 && r == 5) ? 32'hDEAD_BEEF : (32'h1000_0000 | r);
            for (int j = 0; j < 4; j++) s.push_back(w[8*j +: 8]);
        end
        for (int k = 0; k < nbytes; k++) begin
            if (i == 0) exp_q0.push_back(s[k]);
            else        exp_q1.push_back(s[k]);
        end
    endtask

    // UART monitors (one per instance) and done-pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic r;
            logic t;
            int   bd;
            r  = (i == 0) ? rst_a : rst_b;
            t  = (i == 0) ? if_a.tx : if_b.tx;
            bd = (i == 0) ? BA : BB;
            if (!r) done_cnt[i] += ((i == 0) ? int'(if_a.done) : int'(if_b.done));
            if (r) begin
                rx_cnt[i] = -1;
            end else if (rx_cnt[i] < 0) begin
                if (t === 1'b0) rx_cnt[i] = 0;
            end else begin
                rx_cnt[i]++;
                if (rx_cnt[i] == 9*bd + bd/2) begin
                    check("uart_stop_bit", {31'd0, t}, 32'd1);
                    got_byte(i, rx_sh[i]);
                    rx_cnt[i] = -1;
                end else if (rx_cnt[i] > bd && (rx_cnt[i] % bd) == bd/2) begin
                    rx_sh[i] = {t, rx_sh[i][7:1]};
                end
            end
        end
    end

    // Tracks how long regAddr has been stable, for the capture-window model
    always @(negedge clk) begin
        if (if_a.regAddr != last_addr_a) stab_a = 0;
        else                             stab_a++;
        last_addr_a = if_a.regAddr;
        garb_a = $urandom;
        if (garb_a == 32'hDEAD_BEEF) garb_a = 32'h0;
    end

    task automatic run_a(bit pulses);
        int c;
        int d0;
        bit seen;
        d0 = done_cnt[0];
        @(negedge clk);
        if_a.start = 1'b1;
        @(posedge clk); #1;
        if_a.start = 1'b0;
        c = 1;
        check("a_start_busy", {31'd0, if_a.busy}, 32'd1);
        check("a_start_tx", {31'd0, if_a.tx}, 32'd0);
        seen = 1'b0;
        while (!seen && c < LIMIT) begin
            @(posedge clk); #1;
            c++;
            if (if_a.done === 1'b1) seen = 1'b1;
            if_a.start = (pulses && if_a.busy === 1'b1 && (c % 37) == 0);
        end
        if_a.start = 1'b0;
        check("a_done_latency", c, DONE_A);
        check("a_done_busy", {31'd0, if_a.busy}, 32'd0);
        check("a_done_addr", {27'd0, if_a.regAddr}, 32'd0);
        @(posedge clk); #1;
        check("a_done_width", {31'd0, if_a.done}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("a_done_count", done_cnt[0] - d0, 1);
        check("a_queue_empty", exp_q0.size(), 0);
        check("a_idle_after", {31'd0, if_a.busy}, 32'd0);
    endtask

    initial begin
        int c;
        int d0;
        bit seen;

        // Reset with start asserted: must be ignored
        rst_a = 1'b1;
        rst_b = 1'b1;
        if_a.start = 1'b1;
        if_b.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", {31'd0, if_a.tx}, 32'd1);
        check("rst_busy", {31'd0, if_a.busy}, 32'd0);
        check("rst_done", {31'd0, if_a.done}, 32'd0);
        check("rst_addr", {27'd0, if_a.regAddr}, 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        if_a.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_busy", {31'd0, if_a.busy}, 32'd0);
        check("post_rst_tx", {31'd0, if_a.tx}, 32'd1);

        // Full dump with the straight readout model
        push_stream(0, 1'b0, 129);
        run_a(1'b0);

        // Capture window: reg 5 valid only during CAPT
        mode_a = 1;
        push_stream(0, 1'b1, 129);
        run_a(1'b0);
        mode_a = 0;

        // start pulsed repeatedly while busy
        push_stream(0, 1'b0, 129);
        run_a(1'b1);

        // Reset in the middle of reg 7, byte 2, bit 3
        push_stream(0, 1'b0, 31);
        d0 = done_cnt[0];
        @(negedge clk);
        if_a.start = 1'b1;
        @(posedge clk); #1;
        if_a.start = 1'b0;
        c = 1;
        while (c < ABORT_C) begin
            @(posedge clk); #1;
            c++;
        end
        check("abort_pre_tx", {31'd0, if_a.tx}, 32'd0);
        check("abort_pre_addr", {27'd0, if_a.regAddr}, 32'd7);
        rst_a = 1'b1;
        @(posedge clk); #1;
        check("abort_tx", {31'd0, if_a.tx}, 32'd1);
        check("abort_busy", {31'd0, if_a.busy}, 32'd0);
        check("abort_addr", {27'd0, if_a.regAddr}, 32'd0);
        check("abort_done", {31'd0, if_a.done}, 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt[0] - d0, 0);
        check("abort_queue", exp_q0.size(), 0);
        check("abort_idle_tx", {31'd0, if_a.tx}, 32'd1);

        // Fresh dump after the abort
        push_stream(0, 1'b0, 129);
        run_a(1'b0);

        // start tied high on the fast instance: two back-to-back dumps
        push_stream(1, 1'b0, 129);
        push_stream(1, 1'b0, 129);
        @(negedge clk);
        rst_b = 1'b0;
        if_b.start = 1'b1;
        @(posedge clk); #1;
        c = 1;
        check("b_start_busy", {31'd0, if_b.busy}, 32'd1);
        check("b_start_tx", {31'd0, if_b.tx}, 32'd0);
        seen = 1'b0;
        while (!seen && c < LIMIT) begin
            @(posedge clk); #1;
            c++;
            if (if_b.done === 1'b1) seen = 1'b1;
        end
        check("b_done1_latency", c, DONE_B);
        check("b_done1_tx", {31'd0, if_b.tx}, 32'd1);
        @(posedge clk); #1;
        check("b_idle_tx", {31'd0, if_b.tx}, 32'd1);
        check("b_idle_busy", {31'd0, if_b.busy}, 32'd0);
        @(posedge clk); #1;
        check("b_restart_tx", {31'd0, if_b.tx}, 32'd0);
        check("b_restart_busy", {31'd0, if_b.busy}, 32'd1);
        c = 2;
        seen = 1'b0;
        while (!seen && c < LIMIT) begin
            @(posedge clk); #1;
            c++;
            if (if_b.done === 1'b1) seen = 1'b1;
        end
        if_b.start = 1'b0;
        check("b_done2_latency", c, DONE_B + 1);
        repeat (40) @(posedge clk);
        #1;
        check("b_done_count", done_cnt[1], 2);
        check("b_queue_empty", exp_q1.size(), 0);
        check("b_idle_final", {31'd0, if_b.busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
